// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, instruction-memory read port and IF/ID
// pipeline register, with a BOOT/FETCH/HALT control FSM that stops on BREAK_WORD.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] BREAK_WORD = 32'h0000_000D
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] imem_data,
  output logic        imem_rena,
  output logic [10:0] imem_addr,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_npc,
  output logic        id_valid,
  output logic        halted
);

  localparam int unsigned PC_W   = 32;
  localparam int unsigned WORD_W = PC_W - 2;
  localparam int unsigned ADDR_W = 11;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t              state;
  // Only the word part of the PC is stored, so its byte offset is always 00.
  logic [WORD_W-1:0]   pc_word;
  logic [WORD_W-1:0]   pc_word_inc;
  logic [PC_W-1:0]     pc;
  logic [PC_W-1:0]     pc_inc;
  logic                unused_redirect_offset;

  assign pc_word_inc = pc_word + WORD_W'(1);
  assign pc          = {pc_word, 2'b00};
  assign pc_inc      = {pc_word_inc, 2'b00};

  assign imem_addr = pc_word[ADDR_W-1:0];
  // Read enable is qualified by the live stall so a held cycle issues no access.
  assign imem_rena = (state == FETCH) && !stall;

  assign unused_redirect_offset = ^redirect_pc[1:0];

  // Control FSM together with the PC and IF/ID registers it steers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc_word  <= RESET_PC[PC_W-1:2];
      id_instr <= '0;
      id_pc    <= '0;
      id_npc   <= '0;
      id_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state <= FETCH;
        end
        FETCH: begin
          if (redirect) begin
            // Redirect wins over stall and over a BREAK_WORD in flight.
            pc_word  <= redirect_pc[PC_W-1:2];
            id_instr <= '0;
            id_valid <= 1'b0;
          end else if (!stall) begin
            id_instr <= imem_data;
            id_pc    <= pc;
            id_npc   <= pc_inc;
            id_valid <= 1'b1;
            pc_word  <= pc_word_inc;
            if (imem_data == BREAK_WORD) begin
              state  <= HALT;
              halted <= 1'b1;
            end
          end
        end
        HALT: begin
          id_instr <= '0;
          id_valid <= 1'b0;
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule
